tdm_transmit: RTL and testbench

- TDM serializer: drives one or more audio slots onto the shared SD line of the TDM mic bus, synchronous to an externally generated SCK/WS pair.
- Serves as the transmit end of the tdm_receive link. Used as an on-board microphone-array emulator for loopback and bring-up, and as the source for TDM output to a codec.
- Runs on the 100 MHz system clock. SCK and WS are sampled, never used as clocks.

---
 rtl/tdm_transmit.sv | 198 +++++++++++++++++++
 tb/tb_tdm_transmit.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_transmit.sv
// TDM serializer: shifts SLOTS signed samples MSB-first onto the shared SD line,
// paced by an externally generated SCK/WS pair that is oversampled on clk_in.
module tdm_transmit #(
    parameter int SLOTS        = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            sck_in,
    input  logic                            ws_in,
    input  logic [SLOTS*SAMPLE_WIDTH-1:0]   audio_in,
    input  logic                            audio_valid_in,
    output logic                            ready_out,
    output logic                            sd_out,
    output logic                            sd_oe_out,
    output logic                            frame_start_out,
    output logic                            underrun_out,
    output logic                            frame_error_out
);

    localparam int POS_W   = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int SLOT_CW = $clog2(SLOTS + 1);
    localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(SLOT_WIDTH - 1);
    localparam logic [SLOT_CW-1:0] SLOT_LAST = SLOT_CW'(SLOTS - 1);
    localparam logic [POS_W:0]     DATA_LIM  = (POS_W + 1)'(SAMPLE_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SHIFT
    } state_t;

    typedef logic [SLOTS-1:0][SAMPLE_WIDTH-1:0] frame_t;

    state_t               state_q, state_d;
    frame_t               pending_q, pending_d;
    frame_t               active_q, active_d;
    frame_t               tx_q, tx_d;
    logic                 pending_full_q, pending_full_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [SLOT_CW-1:0]   slot_q, slot_d;
    logic                 sd_q, sd_d;
    logic                 sd_oe_q, sd_oe_d;
    logic                 frame_start_q, frame_start_d;
    logic                 underrun_q, underrun_d;
    logic                 frame_error_q, frame_error_d;
    logic                 sck_meta_q, sck_meta_d;
    logic                 sck_sync_q, sck_sync_d;
    logic                 sck_prev_q, sck_prev_d;
    logic                 ws_meta_q, ws_meta_d;
    logic                 ws_sync_q, ws_sync_d;

    logic                 sck_rise;
    logic                 sck_fall;
    logic                 load;
    logic                 frame_start;
    logic                 last_bit;

    assign sck_rise    = sck_sync_q & ~sck_prev_q;
    assign sck_fall    = ~sck_sync_q & sck_prev_q;
    assign load        = audio_valid_in & ~pending_full_q;
    assign frame_start = sck_rise & ws_sync_q;
    assign last_bit    = (state_q == SHIFT) && (pos_q == POS_LAST) && (slot_q == SLOT_LAST);

    always_comb begin
        sck_meta_d     = sck_in;
        sck_sync_d     = sck_meta_q;
        sck_prev_d     = sck_sync_q;
        ws_meta_d      = ws_in;
        ws_sync_d      = ws_meta_q;
        state_d        = state_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        active_d       = active_q;
        tx_d           = tx_q;
        pos_d          = pos_q;
        slot_d         = slot_q;
        sd_d           = sd_q;
        sd_oe_d        = sd_oe_q;
        frame_start_d  = 1'b0;
        underrun_d     = 1'b0;
        frame_error_d  = 1'b0;

        if (load) begin
            pending_d      = frame_t'(audio_in);
            pending_full_d = 1'b1;
        end

        // A WS rise restarts the frame from any state; a same-cycle load goes straight to active.
        if (frame_start) begin
            frame_start_d = 1'b1;
            state_d       = ARMED;
            if (load) begin
                active_d       = frame_t'(audio_in);
                pending_full_d = 1'b0;
            end else if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
            if ((state_q != IDLE) && !last_bit) begin
                frame_error_d = 1'b1;
            end
        end else if (sck_fall) begin
            case (state_q)
                ARMED: begin
                    tx_d    = active_q;
                    sd_d    = active_q[0][SAMPLE_WIDTH-1];
                    tx_d[0] = active_q[0] << 1;
                    sd_oe_d = 1'b1;
                    pos_d   = '0;
                    slot_d  = '0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (last_bit) begin
                        sd_d    = 1'b0;
                        sd_oe_d = 1'b0;
                        state_d = IDLE;
                    end else if (pos_q == POS_LAST) begin
                        // Slot boundary: the next slot's sample moves into tx_d[0].
                        pos_d  = '0;
                        slot_d = slot_q + 1'b1;
                        for (int i = 0; i < SLOTS - 1; i++) begin
                            tx_d[i] = tx_q[i+1];
                        end
                        tx_d[SLOTS-1] = '0;
                        sd_d          = tx_d[0][SAMPLE_WIDTH-1];
                        tx_d[0]       = tx_d[0] << 1;
                        sd_oe_d       = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                        if ({1'b0, pos_d} < DATA_LIM) begin
                            sd_d    = tx_q[0][SAMPLE_WIDTH-1];
                            tx_d[0] = tx_q[0] << 1;
                            sd_oe_d = 1'b1;
                        end else begin
                            sd_d    = 1'b0;
                            sd_oe_d = 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sck_meta_q     <= 1'b0;
            sck_sync_q     <= 1'b0;
            sck_prev_q     <= 1'b0;
            ws_meta_q      <= 1'b0;
            ws_sync_q      <= 1'b0;
            state_q        <= IDLE;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            active_q       <= '0;
            tx_q           <= '0;
            pos_q          <= '0;
            slot_q         <= '0;
            sd_q           <= 1'b0;
            sd_oe_q        <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            sck_meta_q     <= sck_meta_d;
            sck_sync_q     <= sck_sync_d;
            sck_prev_q     <= sck_prev_d;
            ws_meta_q      <= ws_meta_d;
            ws_sync_q      <= ws_sync_d;
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            active_q       <= active_d;
            tx_q           <= tx_d;
            pos_q          <= pos_d;
            slot_q         <= slot_d;
            sd_q           <= sd_d;
            sd_oe_q        <= sd_oe_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign ready_out       = ~pending_full_q;
    assign sd_out          = sd_q;
    assign sd_oe_out       = sd_oe_q;
    assign frame_start_out = frame_start_q;
    assign underrun_out    = underrun_q;
    assign frame_error_out = frame_error_q;

endmodule

// File: tb/tb_tdm_transmit.sv
// Scoreboard bench for tdm_transmit: SCK = 50 clk, expected {oe,sd} per SCK rise
// is queued from a bit-level frame model and compared against what the line carried.
module tb_tdm_transmit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        ws = 1'b0;
    logic [47:0] audio = '0;
    logic        valid = 1'b0;
    logic        ready_out, sd_out, sd_oe_out;
    logic        frame_start_out, underrun_out, frame_error_out;

    int tests_run = 0;
    int tests_failed = 0;
    int fs_cnt = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    int fs_base, ur_base, fe_base;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    tdm_transmit #(.SLOTS(2), .SAMPLE_WIDTH(24), .SLOT_WIDTH(32)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .sck_in(sck),
        .ws_in(ws),
        .audio_in(audio),
        .audio_valid_in(valid),
        .ready_out(ready_out),
        .sd_out(sd_out),
        .sd_oe_out(sd_oe_out),
        .frame_start_out(frame_start_out),
        .underrun_out(underrun_out),
        .frame_error_out(frame_error_out)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (frame_start_out) fs_cnt++;
            if (underrun_out) ur_cnt++;
            if (frame_error_out) fe_cnt++;
        end
    endtask

    // One SCK period: fall (WS updated) then rise; the line is captured just before the rise.
    task automatic sck_cycle(input logic ws_val);
        sck = 1'b0;
        ws = ws_val;
        wait_clk(25);
        obs_q.push_back({sd_oe_out, sd_out});
        sck = 1'b1;
        wait_clk(25);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) sck_cycle(1'b0);
    endtask

    task automatic load_frame(input logic [23:0] s0, input logic [23:0] s1);
        @(negedge clk);
        audio = {s1, s0};
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic push_frame(input logic [23:0] s0, input logic [23:0] s1, input int nbits);
        logic [23:0] w;
        for (int b = 0; b < nbits; b++) begin
            w = (b < 32) ? s0 : s1;
            if ((b % 32) < 24) exp_q.push_back({1'b1, w[23 - (b % 32)]});
            else exp_q.push_back(2'b00);
        end
    endtask

    task automatic push_released(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
    endtask

    task automatic start_frame();
        exp_q.delete();
        fs_base = fs_cnt;
        ur_base = ur_cnt;
        fe_base = fe_cnt;
        sck_cycle(1'b1);
        obs_q.delete();
    endtask

    task automatic test_reset();
        wait_clk(3);
        tests_run++;
        if ({ready_out, sd_oe_out, sd_out} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready/oe/sd=%b required 100", {ready_out, sd_oe_out, sd_out});
        end
        tests_run++;
        if ({frame_start_out, underrun_out, frame_error_out} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_pulses: got %b required 000", {frame_start_out, underrun_out, frame_error_out});
        end
        rst = 1'b0;
        wait_clk(2);
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ready_after_reset: got %b required 1", ready_out);
        end
    endtask

    task automatic test_idle();
        exp_q.delete();
        obs_q.delete();
        push_released(6);
        run_cycles(6);
        while (exp_q.size() > 0) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL idle_released: got oe/sd=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_basic_frame();
        load_frame(24'hABCDEF, 24'h123456);
        tests_run++;
        if (ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_ready_after_load: got %b required 0", ready_out);
        end
        start_frame();
        push_frame(24'hABCDEF, 24'h123456, 64);
        push_released(4);
        run_cycles(68);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL basic_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base} !== {32'd1, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL basic_pulses: got fs/ur/fe=%0d/%0d/%0d required 1/0/0",
                     fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base);
        end
    endtask

    task automatic test_underrun();
        start_frame();
        push_frame(24'hABCDEF, 24'h123456, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL underrun_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base} !== {32'd1, 32'd1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL underrun_pulses: got fs/ur/fe=%0d/%0d/%0d required 1/1/0",
                     fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base);
        end
    endtask

    task automatic test_double_load();
        load_frame(24'h111111, 24'h222222);
        load_frame(24'h333333, 24'h444444);
        tests_run++;
        if (ready_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL double_ready: got %b required 0", ready_out);
        end
        start_frame();
        push_frame(24'h111111, 24'h222222, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL double_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({ready_out, 32'(ur_cnt - ur_base)} !== {1'b1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL double_after: got ready=%b ur=%0d required ready=1 ur=0", ready_out, ur_cnt - ur_base);
        end
    endtask

    task automatic test_loopback();
        logic [23:0] rx0, rx1;
        rx0 = '0;
        rx1 = '0;
        load_frame(24'h800001, 24'h7FFFFF);
        start_frame();
        push_frame(24'h800001, 24'h7FFFFF, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            if (i < 24) rx0 = {rx0[22:0], o[0]};
            else if (i >= 32 && i < 56) rx1 = {rx1[22:0], o[0]};
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL loopback_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({rx0, rx1} !== {24'h800001, 24'h7FFFFF}) begin
            tests_failed++;
            $display("[TB] FAIL loopback_rx: got %h/%h required 800001/7fffff", rx0, rx1);
        end
    endtask

    task automatic test_back_to_back();
        load_frame(24'h5A5A5A, 24'hC3C3C3);
        start_frame();
        push_frame(24'h5A5A5A, 24'hC3C3C3, 64);
        run_cycles(63);
        load_frame(24'h0F0F0F, 24'hF00001);
        sck_cycle(1'b1);
        push_frame(24'h0F0F0F, 24'hF00001, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL b2b_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base} !== {32'd2, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_pulses: got fs/ur/fe=%0d/%0d/%0d required 2/0/0",
                     fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base);
        end
    endtask

    task automatic test_frame_error();
        load_frame(24'hFEDCBA, 24'h987654);
        start_frame();
        push_frame(24'hFEDCBA, 24'h987654, 11);
        run_cycles(10);
        load_frame(24'h2468AC, 24'h13579B);
        sck_cycle(1'b1);
        push_frame(24'h2468AC, 24'h13579B, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL ferr_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base} !== {32'd2, 32'd0, 32'd1}) begin
            tests_failed++;
            $display("[TB] FAIL ferr_pulses: got fs/ur/fe=%0d/%0d/%0d required 2/0/1",
                     fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base);
        end
    endtask

    task automatic test_reset_mid_frame();
        load_frame(24'hABCDEF, 24'h123456);
        start_frame();
        push_frame(24'hABCDEF, 24'h123456, 41);
        run_cycles(41);
        load_frame(24'h777777, 24'h777777);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL prereset_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({sd_oe_out, ready_out} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL prereset_state: got oe/ready=%b required 10", {sd_oe_out, ready_out});
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({sd_oe_out, sd_out, ready_out} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got oe/sd/ready=%b required 001", {sd_oe_out, sd_out, ready_out});
        end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        start_frame();
        push_frame(24'h000000, 24'h000000, 64);
        push_released(1);
        run_cycles(65);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [1:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("[TB] FAIL postreset_bit %0d: got oe/sd=%b required %b", i, o, e);
            end
        end
        tests_run++;
        if ({fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base} !== {32'd1, 32'd1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL postreset_pulses: got fs/ur/fe=%0d/%0d/%0d required 1/1/0",
                     fs_cnt - fs_base, ur_cnt - ur_base, fe_cnt - fe_base);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic_frame();
        test_underrun();
        test_double_load();
        test_loopback();
        test_back_to_back();
        test_frame_error();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
